// File: rtl/ssm_mux_demux.sv
// Substream demultiplexer for the VDCM decoder: round-robin preload at slice start,
// then mux words are routed to substreams in the order they consumed their head words.
module ssm_mux_demux #(
    parameter int N_SSM   = 4,
    parameter int DW      = 128,
    parameter int DEPTH   = 4,
    parameter int PRELOAD = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [DW-1:0]         in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_SSM-1:0]      ssm_rd_en,
    output logic [N_SSM*DW-1:0]   ssm_data,
    output logic [N_SSM-1:0]      ssm_vld,
    output logic                  preload_done,
    output logic                  underflow_err
);

    localparam int IW  = $clog2(N_SSM);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int QD  = N_SSM * DEPTH;
    localparam int QW  = $clog2(QD);
    localparam int QW1 = QW + 1;
    localparam int NPL = N_SSM * PRELOAD;
    localparam int LW  = $clog2(NPL + 1);

    localparam logic [QW:0]   QD_W     = QW1'(QD);
    localparam logic [QW:0]   Q_ONE    = QW1'(1);
    localparam logic [LW-1:0] PL_LAST  = LW'(NPL - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_SSM - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRELOAD,
        S_STREAM
    } state_t;

    state_t         state_q, state_d;
    logic           in_ready_q;
    logic           preload_done_q;
    logic           underflow_q, underflow_d;
    logic [LW-1:0]  pl_cnt_q, pl_cnt_d;
    logic [IW-1:0]  pl_idx_q, pl_idx_d;

    logic [IW-1:0]  rq_mem_q [QD];
    logic [QW-1:0]  rq_wr_q, rq_wr_d;
    logic [QW-1:0]  rq_rd_q, rq_rd_d;
    logic [QW:0]    rq_cnt_q, rq_cnt_d;
    logic [QW-1:0]  rq_pos [N_SSM];
    logic [QW:0]    push_n;
    logic [QW:0]    pop_n;

    logic [N_SSM-1:0] hon;
    logic             accept;
    logic             pop;
    logic [IW-1:0]    dest;

    // Modular add for the request ring; the ring length need not be a power of two.
    function automatic logic [QW-1:0] q_add(input logic [QW-1:0] base, input logic [QW:0] inc);
        logic [QW:0] sum;
        sum = {1'b0, base} + inc;
        if (sum >= QD_W) begin
            sum = sum - QD_W;
        end
        return sum[QW-1:0];
    endfunction

    assign in_ready      = in_ready_q;
    assign preload_done  = preload_done_q;
    assign underflow_err = underflow_q;

    assign hon    = ssm_rd_en & ssm_vld;
    assign accept = in_valid && in_ready_q && !start;
    assign pop    = accept && (state_q == S_STREAM);
    assign dest   = (state_q == S_PRELOAD) ? pl_idx_q : rq_mem_q[rq_rd_q];
    assign pop_n  = pop ? Q_ONE : '0;

    for (genvar gi = 0; gi < N_SSM; gi++) begin : g_fifo
        logic [DW-1:0] mem_q [DEPTH];
        logic [PW-1:0] wr_ptr_q;
        logic [PW-1:0] rd_ptr_q;
        logic [CW-1:0] cnt_q;
        logic          wr_en;
        logic          rd_en;

        assign wr_en = accept && (dest == IW'(gi));
        assign rd_en = hon[gi];

        always_ff @(posedge clk) begin
            if (!rstn || start) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                end
                if (rd_en) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
                if (wr_en && !rd_en) begin
                    cnt_q <= cnt_q + CW'(1);
                end else if (rd_en && !wr_en) begin
                    cnt_q <= cnt_q - CW'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= in_data;
            end
        end

        assign ssm_vld[gi]            = (cnt_q != '0);
        assign ssm_data[gi*DW +: DW]  = ssm_vld[gi] ? mem_q[rd_ptr_q] : '0;
    end

    // Same-cycle requests take consecutive ring slots in ascending substream order.
    always_comb begin
        logic [QW:0] off;
        off = '0;
        for (int i = 0; i < N_SSM; i++) begin
            rq_pos[i] = q_add(rq_wr_q, off);
            if (hon[i]) begin
                off = off + Q_ONE;
            end
        end
        push_n   = off;
        rq_wr_d  = q_add(rq_wr_q, off);
        rq_rd_d  = pop ? q_add(rq_rd_q, Q_ONE) : rq_rd_q;
        rq_cnt_d = rq_cnt_q + push_n - pop_n;
    end

    always_comb begin
        state_d     = state_q;
        pl_cnt_d    = pl_cnt_q;
        pl_idx_d    = pl_idx_q;
        underflow_d = underflow_q | (|(ssm_rd_en & ~ssm_vld));
        if (state_q == S_PRELOAD && accept) begin
            pl_cnt_d = pl_cnt_q + LW'(1);
            pl_idx_d = (pl_idx_q == IDX_LAST) ? '0 : pl_idx_q + IW'(1);
            if (pl_cnt_q == PL_LAST) begin
                state_d = S_STREAM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q        <= S_IDLE;
            in_ready_q     <= 1'b0;
            preload_done_q <= 1'b0;
            underflow_q    <= 1'b0;
            pl_cnt_q       <= '0;
            pl_idx_q       <= '0;
            rq_wr_q        <= '0;
            rq_rd_q        <= '0;
            rq_cnt_q       <= '0;
        end else if (start) begin
            state_q        <= S_PRELOAD;
            in_ready_q     <= 1'b1;
            preload_done_q <= 1'b0;
            underflow_q    <= 1'b0;
            pl_cnt_q       <= '0;
            pl_idx_q       <= '0;
            rq_wr_q        <= '0;
            rq_rd_q        <= '0;
            rq_cnt_q       <= '0;
        end else begin
            state_q        <= state_d;
            in_ready_q     <= (state_d == S_PRELOAD) || ((state_d == S_STREAM) && (rq_cnt_d != '0));
            preload_done_q <= (state_d == S_STREAM);
            underflow_q    <= underflow_d;
            pl_cnt_q       <= pl_cnt_d;
            pl_idx_q       <= pl_idx_d;
            rq_wr_q        <= rq_wr_d;
            rq_rd_q        <= rq_rd_d;
            rq_cnt_q       <= rq_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && !start) begin
            for (int i = 0; i < N_SSM; i++) begin
                if (hon[i]) begin
                    rq_mem_q[rq_pos[i]] <= IW'(i);
                end
            end
        end
    end

endmodule
